// File: rtl/sine_burst_if.sv
// Control/status bundle between a burst requester and the sine LUT sequencer.
// master drives the request side, slave is the sequencer.
interface sine_burst_if #(
  parameter int ADDR_W = 9,
  parameter int STEP_W = 9,
  parameter int CNT_W  = 16
);
  logic              start;
  logic              abort;
  logic [STEP_W-1:0] step;
  logic [CNT_W-1:0]  num_periods;
  logic [ADDR_W-1:0] lut_addr;
  logic              lut_en;
  logic              period_tick;
  logic              busy;
  logic              done;

  modport master (
    output start, abort, step, num_periods,
    input  lut_addr, lut_en, period_tick, busy, done
  );

  modport slave (
    input  start, abort, step, num_periods,
    output lut_addr, lut_en, period_tick, busy, done
  );
endinterface

// File: rtl/sine_burst_ctrl.sv
// Phase-accumulator address sequencer for a 2**ADDR_W-entry sine LUT, emitting a burst
// of whole periods. Define SINE_BURST_CONTINUOUS_EN to let num_periods == 0 run until abort.
module sine_burst_ctrl #(
  parameter int ADDR_W = 9,
  parameter int STEP_W = 9,
  parameter int CNT_W  = 16
) (
  input logic         clk,
  input logic         rst,
  sine_burst_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              en_q, en_d;
  logic              tick_q, tick_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W:0]   sum;
  logic              is_cont;
  logic              accept_cnt;

`ifdef SINE_BURST_CONTINUOUS_EN
  logic cont_q, cont_d;
  assign is_cont    = cont_q;
  assign accept_cnt = 1'b1;
`else
  assign is_cont    = 1'b0;
  assign accept_cnt = (bus.num_periods != '0);
`endif

  // The carry out of the widened sum is the period wrap.
  assign sum = {1'b0, addr_q} + (ADDR_W+1)'(step_q);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= '0;
      rem_q   <= '0;
      addr_q  <= '0;
      en_q    <= 1'b0;
      tick_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SINE_BURST_CONTINUOUS_EN
      cont_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      rem_q   <= rem_d;
      addr_q  <= addr_d;
      en_q    <= en_d;
      tick_q  <= tick_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SINE_BURST_CONTINUOUS_EN
      cont_q  <= cont_d;
`endif
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    rem_d   = rem_q;
    addr_d  = addr_q;
    en_d    = en_q;
    busy_d  = busy_q;
    tick_d  = 1'b0;
    done_d  = 1'b0;
`ifdef SINE_BURST_CONTINUOUS_EN
    cont_d  = cont_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort && (bus.step != '0) && accept_cnt) begin
          state_d = RUN;
          step_d  = bus.step;
          rem_d   = bus.num_periods;
          addr_d  = '0;
          en_d    = 1'b1;
          busy_d  = 1'b1;
`ifdef SINE_BURST_CONTINUOUS_EN
          cont_d  = (bus.num_periods == '0);
`endif
        end
      end
      RUN: begin
        if (bus.abort) begin
          // Abort also pre-empts a coincident final wrap: no tick, no done.
          state_d = IDLE;
          addr_d  = '0;
          en_d    = 1'b0;
          busy_d  = 1'b0;
        end else begin
          addr_d = sum[ADDR_W-1:0];
          if (sum[ADDR_W]) begin
            tick_d = 1'b1;
            if (!is_cont && (rem_q == CNT_W'(1))) begin
              state_d = IDLE;
              addr_d  = '0;
              en_d    = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else if (!is_cont) begin
              rem_d = rem_q - CNT_W'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.lut_addr    = addr_q;
  assign bus.lut_en      = en_q;
  assign bus.period_tick = tick_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
endmodule
